// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// FSM state encoding and iteration-counter sizing.
package div_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Counter must reach WIDTH (it increments on the final CALC cycle too).
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             unused_bits;

    assign shifted = {rem_in, bit_in};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit   = ~diff[WIDTH+1];
    // rem_in < divisor, so both candidates always fit in WIDTH bits.
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    assign unused_bits = ^{diff[WIDTH], shifted[WIDTH]};

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider (restoring, one bit per cycle, magnitude then sign fix).
// Optional macro DIV_ZERO_DETECT_EN: short-circuit b==0 straight to FIX and raise dz.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, step_rem;
    logic             step_q, q_neg, r_neg, calc_last, zero_b;

`ifdef DIV_ZERO_DETECT_EN
    logic zero_q;
    assign zero_b = (b == '0);
`else
    assign zero_b = 1'b0;
    assign dz     = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign calc_last = (cnt == CW'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (quo_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_b ? FIX : CALC;
            CALC:    if (calc_last) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // quo_q starts as |a| and shifts out dividend bits as quotient bits shift in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            zero_q    <= 1'b0;
            dz        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt   <= '0;
                    rem_q <= '0;
                    quo_q <= a[WIDTH-1] ? -a : a;
                    dvs_q <= b[WIDTH-1] ? -b : b;
                    q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                    r_neg <= a[WIDTH-1];
`ifdef DIV_ZERO_DETECT_EN
                    zero_q <= zero_b;
`endif
                end
                CALC: begin
                    cnt   <= cnt + CW'(1);
                    rem_q <= step_rem;
                    quo_q <= {quo_q[WIDTH-2:0], step_q};
                end
                FIX: begin
                    done      <= 1'b1;
                    quotient  <= q_neg ? -quo_q : quo_q;
                    remainder <= r_neg ? -rem_q : rem_q;
`ifdef DIV_ZERO_DETECT_EN
                    dz <= zero_q;
                    if (zero_q) begin
                        quotient  <= '1;
                        remainder <= r_neg ? -quo_q : quo_q;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (WIDTH=8): arithmetic reference
// model with per-cycle compare, plus directed vectors with literal expectations.
module tb_seq_signed_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, dz;
    logic [7:0] quotient, remainder;

    seq_signed_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         due;
    } exp_t;

    int   tests = 0, fails = 0, cyc = 0;
    bit   model_busy = 1'b0;
    int   model_end = 0;
    exp_t expq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division (truncating), divide-by-zero rules, latency.
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        int sa, sb, qi, ri;
        sa = $signed(av);
        sb = $signed(bv);
        if (sb == 0) begin
            e.r = av;
`ifdef DIV_ZERO_DETECT_EN
            e.q = 8'hFF; e.dz = 1'b1; e.due = 1;
`else
            e.q = (sa < 0) ? 8'h01 : 8'hFF; e.dz = 1'b0; e.due = 9;
`endif
        end else begin
            qi = sa / sb;
            ri = sa % sb;
            e.q = qi[7:0]; e.r = ri[7:0]; e.dz = 1'b0; e.due = 9;
        end
        return e;
    endfunction

    // Acceptance/busy tracking at each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                expq.delete();
                model_busy = 1'b0;
            end else if (model_busy && cyc == model_end) begin
                model_busy = 1'b0;
            end else if (!model_busy && start) begin
                e = model(a, b);
                e.due += cyc;
                model_end = e.due;
                model_busy = 1'b1;
                expq.push_back(e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy", busy, model_busy);
                if (done) begin
                    if (expq.size() == 0) chk("spurious_done", done, 0);
                    else begin
                        e = expq.pop_front();
                        chk("model_q", quotient, e.q);
                        chk("model_r", remainder, e.r);
                        chk("model_dz", dz, e.dz);
                        chk("done_time", cyc, e.due);
                    end
                end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                    chk("missing_done", done, 1);
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic wait_done(input string nm, input int k, input logic [7:0] eq,
                             input logic [7:0] er, input logic edz, input int elat);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk({nm, "_q"}, quotient, eq);
                chk({nm, "_r"}, remainder, er);
                chk({nm, "_dz"}, dz, edz);
                chk({nm, "_lat"}, cyc - k, elat);
            end
        end
        if (!seen) chk({nm, "_timeout"}, done, 1);
    endtask

    task automatic run_op(input string nm, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz, input int elat);
        int k;
        @(negedge clk); #1;
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        k = cyc;
        chk({nm, "_busy"}, busy, 1);
        #1 start = 1'b0;
        wait_done(nm, k, eq, er, edz, elat);
        @(negedge clk);
        chk({nm, "_hold_q"}, quotient, eq);
        chk({nm, "_done_low"}, done, 0);
    endtask

    initial begin
        int k, k2;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", dz, 0);
        #1 rst_n = 1'b1;

        run_op("p100_7",   8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 9);
        run_op("m100_7",   8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 9);
        run_op("p36_m8",   8'd36,  8'hF8,  8'hFC, 8'h04, 1'b0, 9);
        run_op("m127_m127",8'h81,  8'h81,  8'h01, 8'h00, 1'b0, 9);
        run_op("ovf",      8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 9);
        run_op("p7_100",   8'd7,   8'd100, 8'h00, 8'h07, 1'b0, 9);
        run_op("m7_100",   8'hF9,  8'd100, 8'h00, 8'hF9, 1'b0, 9);
        run_op("p127_1",   8'd127, 8'd1,   8'h7F, 8'h00, 1'b0, 9);
`ifdef DIV_ZERO_DETECT_EN
        run_op("p5_0",     8'd5,   8'd0,   8'hFF, 8'h05, 1'b1, 1);
        run_op("m5_0",     8'hFB,  8'd0,   8'hFF, 8'hFB, 1'b1, 1);
`else
        run_op("p5_0",     8'd5,   8'd0,   8'hFF, 8'h05, 1'b0, 9);
        run_op("m5_0",     8'hFB,  8'd0,   8'h01, 8'hFB, 1'b0, 9);
`endif

        // start re-pulsed and operands changed while busy
        @(negedge clk); #1;
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(negedge clk);
        k = cyc;
        #1 start = 1'b0;
        @(negedge clk); #1;
        start = 1'b1; a = 8'd3; b = 8'd1;
        repeat (2) @(negedge clk);
        #1 start = 1'b0; a = 8'h55;
        wait_done("ignore", k, 8'h0E, 8'h02, 1'b0, 9);

        // reset in the middle of CALC discards the operation
        @(negedge clk); #1;
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        chk("midrst_dz", dz, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk); #1;
        rst_n = 1'b1; start = 1'b1; a = 8'hF9; b = 8'd2;
        @(negedge clk);
        k = cyc;
        chk("release_busy", busy, 1);
        #1 start = 1'b0;
        wait_done("after_rst", k, 8'hFD, 8'hFF, 1'b0, 9);

        // back-to-back: start held across the done cycle
        @(negedge clk); #1;
        a = 8'd36; b = 8'hF8; start = 1'b1;
        @(negedge clk);
        k = cyc;
        #1 a = 8'h9C; b = 8'd7;
        wait_done("b2b1", k, 8'hFC, 8'h04, 1'b0, 9);
        k2 = cyc + 1;
        @(negedge clk);
        chk("b2b_accept", busy, 1);
        #1 start = 1'b0;
        wait_done("b2b2", k2, 8'hF2, 8'hFE, 1'b0, 9);

        repeat (12) @(negedge clk);
        chk("queue_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_signed_divider.md
SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; all values below are given for WIDTH=8.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 a  input  WIDTH  signed two's-complement dividend.
REQ-006 b  input  WIDTH  signed two's-complement divisor.
REQ-007 busy  output  1  high from the edge that accepts start until the edge that asserts done.
REQ-008 done  output  1  one-cycle pulse; quotient, remainder and dz are valid when high.
REQ-009 quotient  output  WIDTH  signed quotient, truncated toward zero.
REQ-010 remainder  output  WIDTH  signed remainder; sign follows dividend; |remainder| < |b|.
REQ-011 dz  output  1  divide-by-zero flag, valid with done.

Function
REQ-012 FSM states IDLE, CALC, FIX; CALC runs WIDTH iterations under a counter.
REQ-013 IDLE with start=1 at edge k: a, b captured; magnitudes |a|, |b| loaded as WIDTH-bit unsigned (|-128| = 128); quotient sign = a[MSB]^b[MSB] stored; go to CALC.
REQ-014 CALC: one restoring step per cycle, MSB first: shift partial remainder left, subtract |b|, set quotient bit to 1 if non-negative, else restore and set 0.
REQ-015 After WIDTH CALC cycles, go to FIX: apply signs, register quotient/remainder/dz, assert done, go to IDLE.
REQ-016 Nominal latency: done high in the cycle after edge k+WIDTH+1 (k+9 for WIDTH=8); busy falls at that same edge.
REQ-017 start while busy=1 is ignored; a/b changes after edge k do not affect the result.
REQ-018 start may be high in the done cycle; it is accepted at that edge, giving back-to-back operation.
REQ-019 quotient, remainder and dz hold their values until the next done; done is low in all other cycles.
REQ-020 Overflow (-128 / -1): quotient = 8'h80 by two's-complement truncation; remainder = 0; no flag.

Reset
REQ-021 rst_n low, at any time including mid-CALC: state IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, dz=0; the in-flight operation is discarded.
REQ-022 After release, the first start is accepted on the first rising edge with rst_n high.

Configuration
REQ-023 Macro DIV_ZERO_DETECT_EN, with it defined: b=0 at the accept edge k goes straight to FIX and skips CALC; done is high after edge k+1; dz=1; quotient=8'hFF; remainder=a.
REQ-024 Without DIV_ZERO_DETECT_EN: dz is tied 0; b=0 runs the full algorithm with nominal latency.
REQ-025 Without the macro, divide-by-zero produces quotient magnitude all ones and remainder magnitude |a|, then sign fix: a>=0 gives quotient=8'hFF, remainder=a; a<0 gives quotient=8'h01, remainder=a.

Structure
REQ-026 Shared package div_pkg holds the WIDTH default, the FSM state enum and the iteration-counter width constant.
REQ-027 One sub-module, div_step: combinational single restoring iteration (partial remainder in, divisor, next remainder out, quotient bit out); instantiated once in the CALC datapath.

Verification
REQ-028 100 / 7 -> quotient=8'h0E, remainder=8'h02, dz=0, done 9 cycles after the accept edge.
REQ-029 -100 / 7 -> quotient=8'hF2, remainder=8'hFE; 36 / -8 -> quotient=8'hFC, remainder=8'h04.
REQ-030 -127 / -127 -> quotient=8'h01, remainder=8'h00; -128 / -1 -> quotient=8'h80, remainder=8'h00.
REQ-031 5 / 0 with macro -> done after 1 cycle, dz=1, quotient=8'hFF, remainder=8'h05; without macro -> done after 9 cycles, quotient=8'hFF, remainder=8'h05; -5 / 0 without macro -> quotient=8'h01, remainder=8'hFB.
REQ-032 start re-pulsed and a/b changed mid-CALC -> ignored, original result delivered; rst_n pulsed low at CALC cycle 4 -> all outputs 0 immediately, no done, next start completes correctly.
REQ-033 Back-to-back: start held high across done -> second result 9 cycles after first done; no done cycle lost or duplicated.
